// File: rtl/uart_operand_loader.sv
// uart_operand_loader: receives an 8N1 UART stream and pairs consecutive good
// bytes into IN / WEIGHT operands for the 8-bit load/multiply stage.
// Latency: operand pair valid 1 cycle after the second byte's stop-bit sample.
// Backpressure: pair held stable while op_valid && !op_ready; a further good
// byte is dropped with a one-cycle overrun pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx           UART serial input (idle high, asynchronous to clk)
//   in_data      IN operand (first byte of the pair)
//   weight_data  WEIGHT operand (second byte of the pair)
//   op_valid     operand pair available, held until accepted
//   op_ready     consumer accepts the pair when op_valid && op_ready
//   busy         receiver not in IDLE
//   framing_err  one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: good byte dropped while a pair was pending
module uart_operand_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] in_data,
  output logic [7:0] weight_data,
  output logic       op_valid,
  input  logic       op_ready,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Pointer encoding: 0 = expecting IN, 1 = expecting WEIGHT, 2 = pair pending.
  localparam logic [1:0] LP_PTR_IN      = 2'd0;
  localparam logic [1:0] LP_PTR_WEIGHT  = 2'd1;
  localparam logic [1:0] LP_PTR_PENDING = 2'd2;

  // Synchroniser, reset to the idle-line level so reset release is not seen
  // as a start bit.
  logic r_rx_meta;
  logic r_rx_s;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_busy;
  logic             r_framing_err;
  logic             r_byte_vld;
  logic [7:0]       r_byte_dat;

  logic [1:0]       r_ptr;
  logic [7:0]       r_in_data;
  logic [7:0]       r_weight_data;
  logic             r_op_valid;
  logic             r_overrun;

  logic             w_accept;

  assign w_accept    = r_op_valid & op_ready;

  assign in_data     = r_in_data;
  assign weight_data = r_weight_data;
  assign op_valid    = r_op_valid;
  assign busy        = r_busy;
  assign framing_err = r_framing_err;
  assign overrun     = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receiver FSM. busy is registered alongside the state so it always equals
  // (state != IDLE) without a decode after the flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_busy        <= 1'b0;
      r_framing_err <= 1'b0;
      r_byte_vld    <= 1'b0;
      r_byte_dat    <= '0;
    end else begin
      r_framing_err <= 1'b0;
      r_byte_vld    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              // Line went back high before mid start bit: a glitch, not a frame.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LP_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == LP_FULL) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_byte_vld <= 1'b1;
              r_byte_dat <= r_shift;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_framing_err <= 1'b1;
              r_state       <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line (break) must not be re-read as a new start bit.
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand assembly and consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= LP_PTR_IN;
      r_in_data     <= '0;
      r_weight_data <= '0;
      r_op_valid    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_byte_vld) begin
        if (w_accept || (r_ptr == LP_PTR_IN)) begin
          // Acceptance in the same cycle frees the slot, so the new byte
          // starts the next pair instead of overrunning.
          r_in_data  <= r_byte_dat;
          r_op_valid <= 1'b0;
          r_ptr      <= LP_PTR_WEIGHT;
        end else if (r_ptr == LP_PTR_WEIGHT) begin
          r_weight_data <= r_byte_dat;
          r_op_valid    <= 1'b1;
          r_ptr         <= LP_PTR_PENDING;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_op_valid <= 1'b0;
        r_ptr      <= LP_PTR_IN;
      end else if (r_framing_err && (r_ptr != LP_PTR_PENDING)) begin
        // A bad frame drops a half-built pair; a complete pending pair is
        // left intact so it stays stable until the consumer takes it.
        r_ptr <= LP_PTR_IN;
      end
    end
  end

endmodule

// File: tb/tb_uart_operand_loader.sv
module tb_uart_operand_loader;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] in_data;
  logic [7:0] weight_data;
  logic       op_valid;
  logic       op_ready;
  logic       busy;
  logic       framing_err;
  logic       overrun;

  uart_operand_loader #(.CLKS_PER_BIT(CPB), .CNT_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .in_data     (in_data),
    .weight_data (weight_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state, written only by the monitor process.
  int         m_pairs   = 0;
  int         m_vcycles = 0;
  int         m_ovr     = 0;
  int         m_fe      = 0;
  int         m_busy    = 0;
  int         m_hold    = 0;
  int         m_width   = 0;
  int         m_coin    = 0;
  logic [7:0] m_cap_in  = 8'h00;
  logic [7:0] m_cap_w   = 8'h00;
  logic       p_vld = 1'b0, p_ovr = 1'b0, p_fe = 1'b0;
  logic [7:0] p_in = 8'h00, p_w = 8'h00;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (op_valid && !p_vld) begin
        m_pairs  = m_pairs + 1;
        m_cap_in = in_data;
        m_cap_w  = weight_data;
      end
      if (op_valid)    m_vcycles = m_vcycles + 1;
      if (overrun)     m_ovr = m_ovr + 1;
      if (framing_err) m_fe = m_fe + 1;
      if (busy)        m_busy = m_busy + 1;
      // Pending pair must stay frozen across an edge where op_ready was low.
      if (p_vld && !op_ready &&
          (!op_valid || in_data != p_in || weight_data != p_w))
        m_hold = m_hold + 1;
      if ((overrun && p_ovr) || (framing_err && p_fe)) m_width = m_width + 1;
      if ((overrun || framing_err) && (in_data != p_in || weight_data != p_w))
        m_coin = m_coin + 1;
    end
    p_vld = op_valid;
    p_ovr = overrun;
    p_fe  = framing_err;
    p_in  = in_data;
    p_w   = weight_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; rx is left at the stop level so a low stop can run on
  // into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] exp_in;
    logic [7:0] exp_w;
  } vec_t;

  vec_t vecs[5];

  int base_pairs, base_ovr, base_fe, base_vc, base_busy;

  task automatic snap();
    base_pairs = m_pairs;
    base_ovr   = m_ovr;
    base_fe    = m_fe;
    base_vc    = m_vcycles;
    base_busy  = m_busy;
  endtask

  initial begin
    vecs[0] = '{b0: 8'h35, b1: 8'hA7, exp_in: 8'h35, exp_w: 8'hA7};
    vecs[1] = '{b0: 8'h00, b1: 8'hFF, exp_in: 8'h00, exp_w: 8'hFF};
    vecs[2] = '{b0: 8'h81, b1: 8'h7E, exp_in: 8'h81, exp_w: 8'h7E};
    vecs[3] = '{b0: 8'hC6, b1: 8'h01, exp_in: 8'hC6, exp_w: 8'h01};
    vecs[4] = '{b0: 8'h5A, b1: 8'h80, exp_in: 8'h5A, exp_w: 8'h80};

    rx = 1'b1;
    op_ready = 1'b1;
    rst_n = 1'b0;
    idle(3);
    check("rst_in_data", in_data, 8'h00);
    check("rst_weight", weight_data, 8'h00);
    check("rst_op_valid", op_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_framing", framing_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    idle(5);
    check("post_rst_busy", busy, 1'b0);

    // Table-driven pairs with the consumer always ready.
    for (int v = 0; v < 5; v++) begin
      snap();
      send_byte(vecs[v].b0);
      send_byte(vecs[v].b1);
      idle(6);
      check($sformatf("vec%0d_pairs", v), m_pairs - base_pairs, 1);
      check($sformatf("vec%0d_vcycles", v), m_vcycles - base_vc, 1);
      check($sformatf("vec%0d_in", v), m_cap_in, vecs[v].exp_in);
      check($sformatf("vec%0d_w", v), m_cap_w, vecs[v].exp_w);
      check($sformatf("vec%0d_errs", v), (m_ovr - base_ovr) + (m_fe - base_fe), 0);
    end

    // Overrun with consumer stalled.
    op_ready = 1'b0;
    snap();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    idle(6);
    check("ovr_pairs", m_pairs - base_pairs, 1);
    check("ovr_in", in_data, 8'h12);
    check("ovr_w", weight_data, 8'h34);
    check("ovr_valid_held", op_valid, 1'b1);
    check("ovr_pulses", m_ovr - base_ovr, 1);
    op_ready = 1'b1;
    idle(1);
    op_ready = 1'b0;
    check("ovr_accept_valid", op_valid, 1'b0);
    check("ovr_hold_in", in_data, 8'h12);
    send_byte(8'h78);
    send_byte(8'h9A);
    idle(4);
    check("ovr_next_in", in_data, 8'h78);
    check("ovr_next_w", weight_data, 8'h9A);
    check("ovr_next_valid", op_valid, 1'b1);
    op_ready = 1'b1;
    idle(2);
    check("ovr_next_accepted", op_valid, 1'b0);

    // Framing error into a break, then recovery.
    snap();
    send_byte(8'h11);
    send_frame(8'h22, 1'b0);
    idle(40);
    check("fe_pulses", m_fe - base_fe, 1);
    check("fe_no_pair", m_pairs - base_pairs, 0);
    check("fe_break_busy", busy, 1'b1);
    rx = 1'b1;
    idle(6);
    check("fe_break_exit", busy, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    idle(6);
    check("fe_rec_pairs", m_pairs - base_pairs, 1);
    check("fe_rec_in", m_cap_in, 8'h33);
    check("fe_rec_w", m_cap_w, 8'h44);
    check("fe_rec_no_ovr", m_ovr - base_ovr, 0);

    // Short glitch on the line is not a start bit.
    snap();
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(15);
    check("gl_busy_seen", (m_busy - base_busy) > 0, 1'b1);
    check("gl_busy_dropped", busy, 1'b0);
    check("gl_in_kept", in_data, 8'h33);
    check("gl_no_events", (m_pairs - base_pairs) + (m_fe - base_fe) + (m_ovr - base_ovr), 0);
    send_byte(8'hFF);
    send_byte(8'h00);
    idle(6);
    check("gl_pairs", m_pairs - base_pairs, 1);
    check("gl_in", m_cap_in, 8'hFF);
    check("gl_w", m_cap_w, 8'h00);

    // Reset in the middle of a frame with a pair pending.
    op_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle(4);
    check("mr_pending", op_valid, 1'b1);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      idle(CPB);
    end
    rx = 1'b1;
    idle(CPB / 2);
    check("mr_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_valid", op_valid, 1'b0);
    check("mr_in", in_data, 8'h00);
    check("mr_w", weight_data, 8'h00);
    check("mr_busy", busy, 1'b0);
    idle(3);
    rst_n = 1'b1;
    op_ready = 1'b1;
    idle(3);
    snap();
    send_byte(8'h5A);
    send_byte(8'hC3);
    idle(6);
    check("mr_pairs", m_pairs - base_pairs, 1);
    check("mr_pair_in", m_cap_in, 8'h5A);
    check("mr_pair_w", m_cap_w, 8'hC3);

    // Accept lands in the same cycle the next byte completes.
    op_ready = 1'b0;
    send_byte(8'h10);
    send_byte(8'h20);
    idle(4);
    check("b2b_pending", op_valid, 1'b1);
    snap();
    fork
      send_byte(8'hE1);
      begin
        idle(79);
        op_ready = 1'b1;
        idle(1);
        op_ready = 1'b0;
      end
    join
    idle(4);
    check("b2b_no_ovr", m_ovr - base_ovr, 0);
    check("b2b_in", in_data, 8'hE1);
    check("b2b_valid_low", op_valid, 1'b0);
    send_byte(8'hF2);
    idle(4);
    check("b2b_next_valid", op_valid, 1'b1);
    check("b2b_next_in", in_data, 8'hE1);
    check("b2b_next_w", weight_data, 8'hF2);

    check("hold_violations", m_hold, 0);
    check("pulse_width_violations", m_width, 0);
    check("pulse_update_coincide", m_coin, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_operand_loader.md
Name: uart_operand_loader

Overview:
- Upstream feeder for the 8-bit load/multiply stage.
- Receives a serial UART stream (8N1, LSB first) on one dedicated input pin.
- Assembles two consecutive good bytes into an operand pair: byte 0 is IN, byte 1 is WEIGHT.
- Presents the pair to the multiplier with a valid/ready handshake and reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal range 4..65535.
- CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- rx  input  1  UART serial input, idle high, asynchronous to clk.
- in_data  output  8  IN operand (first byte of pair).
- weight_data  output  8  WEIGHT operand (second byte of pair).
- op_valid  output  1  operand pair available; held until accepted.
- op_ready  input  1  consumer accepts pair when op_valid && op_ready.
- busy  output  1  receiver FSM not in IDLE.
- framing_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because a pair was pending.

Behaviour:
- Reset (async assert, release sync to clk):
  - in_data=0, weight_data=0, op_valid=0, busy=0, framing_err=0, overrun=0.
  - Byte pointer=0, FSM=IDLE, counter=0, synchroniser flops=1.
- Synchroniser: rx passes through 2 flops (rx_s); all FSM decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 -> START, counter=0.
  - START: at counter==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - 0 -> DATA, counter=0, bit index=0.
    - 1 -> false start, return to IDLE with no error.
  - DATA: at counter==CLKS_PER_BIT-1, shift rx_s into shift register (LSB first) and restart the counter. After bit index 7 -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
    - 1 -> good byte, go to IDLE.
    - 0 -> framing_err pulse, byte discarded, byte pointer cleared to 0, go to BREAK.
  - BREAK: wait for rx_s==1, then IDLE. No new start is detected while rx is held low.
- busy=1 in every state except IDLE.
- Operand assembly, on the cycle after a good byte's stop sample:
  - pointer==0: in_data<=byte, pointer<=1.
  - pointer==1: weight_data<=byte, op_valid<=1, pointer<=2.
  - pointer==2 (pair pending): byte dropped, overrun pulse. in_data, weight_data and op_valid unchanged.
- Handshake:
  - When op_valid && op_ready: op_valid<=0 and pointer<=0 on the next edge.
  - in_data/weight_data hold their last values after acceptance until overwritten.
  - op_valid, in_data and weight_data must not change while op_valid=1 and op_ready=0.
- Simultaneous events: accept and good-byte completion in the same cycle -> no overrun; the byte loads as in_data and pointer<=1.
- op_ready while op_valid=0 is ignored.
- Latency:
  - First rx falling edge to start validation: 2 sync cycles + CLKS_PER_BIT/2.
  - Stop sample to op_valid high: 1 cycle.
- Error pulses are exactly 1 cycle wide and never coincide with an in_data/weight_data update.
- Async reset mid-frame aborts the frame: no pulse, no partial operand load, pointer returns to 0.
- Counter never wraps in normal operation; it is cleared on every state transition.

Test Plan:
- CLKS_PER_BIT=8, op_ready=1: send 0x35 then 0xA7 -> single op_valid pulse with in_data=0x35, weight_data=0xA7, 1 cycle after the second stop sample; framing_err=0, overrun=0.
- op_ready=0: send 0x12, 0x34, 0x56 -> op_valid stays high with 0x12/0x34; overrun pulses once after 0x56. Then raise op_ready for 1 cycle -> op_valid=0, pointer=0. Send 0x78, 0x9A -> pair 0x78/0x9A.
- Framing error: send 0x11, then 0x22 with stop bit low -> framing_err pulse, no op_valid. rx held low 40 cycles then idle (BREAK, no restart). Send 0x33, 0x44 -> pair 0x33/0x44.
- Glitch: rx low for 2 cycles (shorter than half bit) -> returns to IDLE, busy drops, no outputs change. Next valid pair 0xFF/0x00 is received correctly.
- Reset mid-frame: assert rst_n=0 during DATA bit 4 of the first byte -> all outputs 0 immediately (async). After release, send 0x5A, 0xC3 -> pair 0x5A/0xC3.
- Back-to-back: pending pair accepted in the same cycle the next byte 0xE1 completes -> no overrun, in_data=0xE1, op_valid=0 until the following byte arrives.
